cam_pixel_decimator: RTL and testbench
======================================

CAM_PIXEL_DECIMATOR -- requirements
Module: cam_pixel_decimator

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning active pixels per camera line.
REQ-002 SHALL have parameter IMG_H, default 480, meaning active lines per camera frame.
REQ-003 SHALL have parameter DEC, default 4, meaning subsample factor in both axes (legal values 1, 2, 4, 8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, at least 2).
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports below.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 enable  in  1  capture enable; sampled only at frame boundaries.
REQ-009 cam_vsync  in  1  OV7670 VSYNC, already synchronised to clk.
REQ-010 cam_href  in  1  OV7670 HREF, already synchronised to clk.
REQ-011 cam_byte_valid  in  1  one-cycle strobe per captured byte.
REQ-012 cam_byte  in  8  RGB565 byte, valid with cam_byte_valid.
REQ-013 pix_valid  out  1  FIFO head holds a pixel.
REQ-014 pix_ready  in  1  consumer accepts the head when pix_valid & pix_ready.
REQ-015 pix_data  out  8  grayscale pixel.
REQ-016 pix_sof  out  1  head pixel is the first kept pixel of a frame.
REQ-017 pix_eol  out  1  head pixel is the last kept pixel of a row.
REQ-018 frame_done  out  1  one-cycle pulse at end of captured frame.
REQ-019 overflow  out  1  sticky flag: a kept pixel was dropped.
REQ-020 clear_ovf  in  1  clears overflow.

Function
REQ-021 SHALL implement FSM with states IDLE, SYNC, CAPTURE.
- IDLE -> SYNC when enable=1.
- SYNC -> CAPTURE on the cycle cam_vsync falls (1->0).
- CAPTURE -> SYNC on a cam_vsync rise if enable=1, otherwise CAPTURE -> IDLE.
REQ-022 SHALL pulse frame_done for exactly one cycle on the CAPTURE exit transition.
REQ-023 SHALL ignore bytes outside CAPTURE or while cam_href=0.
REQ-024 SHALL reset the byte phase to "high byte" on every cam_href rise.
- High byte = RRRRRGGG; low byte = GGGBBBBB.
- A pixel completes on the low byte.
REQ-025 SHALL keep the column counter at 0 at line start and increment it per completed pixel.
- Row counter is 0 at CAPTURE entry and increments on each cam_href fall.
- Counters saturate; pixels with col>=IMG_W or row>=IMG_H are discarded.
REQ-026 SHALL keep a pixel only when col%DEC==0 and row%DEC==0.
REQ-027 SHALL expand channels to 8 bits: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}.
REQ-028 SHALL compute gray=(77*r8+150*g8+29*b8)>>8 in 16-bit arithmetic, truncating (no rounding).
REQ-029 SHALL use a one-stage pipeline.
- Low byte accepted in cycle N -> entry written to the FIFO at the end of N+1.
- pix_valid high in N+2 if the FIFO was empty.
REQ-030 SHALL store pix_sof and pix_eol in the FIFO alongside each pixel.
- sof: first kept pixel of the frame (row 0, col 0).
- eol: col==IMG_W-DEC.
REQ-031 SHALL hold the FIFO head stable while pix_valid=1 and pix_ready=0.
REQ-032 SHALL drop a kept pixel whose write finds the FIFO full, and set overflow.
- A pop in the same cycle frees a slot, so that write succeeds.
REQ-033 SHALL clear overflow on clear_ovf=1; a simultaneous set wins.
REQ-034 SHALL let enable=0 mid-frame finish the current frame, then go to IDLE.
REQ-035 SHALL keep the FIFO contents across frame boundaries (only reset flushes them).

Reset
REQ-036 SHALL, on rst=1, set the following on the next edge:
- FSM to IDLE; FIFO empty; pipeline cleared.
- pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, frame_done=0, overflow=0.
REQ-037 SHALL, after rst mid-frame, ignore the remainder of that frame and start capture only after the next vsync fall.

Verification
REQ-038 Full frame, DEC=4, IMG_W=640, IMG_H=480, pix_ready=1 -> check:
- 19200 pixels out; first pixel has sof=1.
- 120 eol pixels; frame_done pulses once.
REQ-039 Pixel bytes 0xF8,0x00 (pure red) -> pix_data=76; bytes 0xFF,0xFF -> 255; bytes 0x07,0xE0 (green) -> 149.
REQ-040 Hold pix_ready=0 for a whole line with FIFO_DEPTH=4 -> check:
- Exactly 4 pixels retained, overflow=1.
- clear_ovf asserted alone -> overflow=0 next cycle.
REQ-041 Deassert enable mid-frame -> current frame completes, frame_done pulses, FSM returns to IDLE, next frame yields no pixels.
REQ-042 Assert rst mid-line -> check:
- Outputs zero next cycle and FIFO empty.
- Remainder of the frame is ignored.
- Next frame's first pixel has sof=1.
REQ-043 Insert an odd byte count before a cam_href fall -> next line still pairs bytes high/low correctly (gray values match the reference model).

Source files
------------

// File: rtl/cam_pixel_decimator.sv
// -----------------------------------------------------------------------------
// cam_pixel_decimator
//
// Captures an OV7670-style RGB565 byte stream, converts every kept pixel to
// 8-bit grayscale and decimates it by DEC in both axes.
//
// Kept pixels go into a small FIFO. Each FIFO entry carries two framing flags
// along with the pixel value.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   enable         capture enable, only looked at on frame boundaries
//   cam_vsync      camera VSYNC (already synchronised to clk)
//   cam_href       camera HREF  (already synchronised to clk)
//   cam_byte_valid one-cycle strobe per camera byte
//   cam_byte       RGB565 byte, high byte (RRRRRGGG) first, then low (GGGBBBBB)
//   pix_valid      FIFO head holds a pixel
//   pix_ready      consumer takes the head when pix_valid & pix_ready
//   pix_data       grayscale value of the head pixel
//   pix_sof        head pixel is the first kept pixel of its frame
//   pix_eol        head pixel is the last kept pixel of its row
//   frame_done     one-cycle pulse when a captured frame ends
//   overflow       sticky: a kept pixel was dropped on a full FIFO
//   clear_ovf      clears overflow (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module cam_pixel_decimator #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int DEC        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic       cam_byte_valid,
    input  logic [7:0] cam_byte,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [7:0] pix_data,
    output logic       pix_sof,
    output logic       pix_eol,
    output logic       frame_done,
    output logic       overflow,
    input  logic       clear_ovf
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_H);
    localparam logic [31:0]      W_U      = 32'(IMG_W);
    localparam logic [31:0]      H_U      = 32'(IMG_H);
    localparam logic [31:0]      DEC_U    = 32'(DEC);
    localparam logic [31:0]      EOL_COL  = 32'(IMG_W - DEC);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;

    logic             vsync_d;
    logic             href_d;
    logic             phase_low;
    logic [7:0]       high_byte;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic             vsync_rise;
    logic             vsync_fall;
    logic             href_rise;
    logic             href_fall;
    logic             byte_take;
    logic             eff_low;
    logic             pixel_done;
    logic [31:0]      col_ext;
    logic [31:0]      row_ext;
    logic             keep;
    logic             is_sof;
    logic             is_eol;

    // Pipeline stage between byte capture and FIFO write
    logic             stg_valid;
    logic [15:0]      stg_pix;
    logic             stg_sof;
    logic             stg_eol;

    logic [7:0]       r8;
    logic [7:0]       g8;
    logic [7:0]       b8;
    logic [15:0]      gray_sum;

    // FIFO storage: {gray, sof, eol}
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             wr_ok;
    logic             drop;
    logic [9:0]       head;

    // Edge detection and the keep/discard decision for the current byte.
    // A byte arriving on the same cycle as the HREF rise is already a high
    // byte, so the phase register is bypassed on that cycle.
    always_comb begin
        vsync_rise = cam_vsync & ~vsync_d;
        vsync_fall = ~cam_vsync & vsync_d;
        href_rise  = cam_href & ~href_d;
        href_fall  = ~cam_href & href_d;
        byte_take  = (state == CAPTURE) && cam_href && cam_byte_valid;
        eff_low    = phase_low & ~href_rise;
        pixel_done = byte_take & eff_low;
        col_ext    = 32'(col);
        row_ext    = 32'(row);
        keep       = pixel_done
                     && (col_ext < W_U) && (row_ext < H_U)
                     && ((col_ext % DEC_U) == 32'd0)
                     && ((row_ext % DEC_U) == 32'd0);
        is_sof     = (col_ext == 32'd0) && (row_ext == 32'd0);
        is_eol     = (col_ext == EOL_COL);
    end

    // Frame state machine plus line/byte tracking. frame_done is a registered
    // pulse raised on the cycle after the VSYNC rise that ends a capture.
    // Column and row counters saturate so that oversized lines or frames
    // simply fall outside the kept window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            phase_low  <= 1'b0;
            high_byte  <= 8'd0;
            col        <= '0;
            row        <= '0;
        end else begin
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (vsync_fall) begin
                        state     <= CAPTURE;
                        row       <= '0;
                        col       <= '0;
                        phase_low <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= enable ? SYNC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (state == CAPTURE) begin
                if (href_rise) begin
                    col       <= '0;
                    phase_low <= 1'b0;
                end
                if (byte_take) begin
                    if (!eff_low) begin
                        high_byte <= cam_byte;
                        phase_low <= 1'b1;
                    end else begin
                        phase_low <= 1'b0;
                        if (col != COL_MAX) begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                if (href_fall && (row != ROW_MAX)) begin
                    row <= row + ROW_W'(1);
                end
            end
        end
    end

    // Single pipeline register: holds the raw RGB565 word and flags of a
    // kept pixel for one cycle while the grayscale value is computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_pix   <= 16'd0;
            stg_sof   <= 1'b0;
            stg_eol   <= 1'b0;
        end else begin
            stg_valid <= keep;
            if (keep) begin
                stg_pix <= {high_byte, cam_byte};
                stg_sof <= is_sof;
                stg_eol <= is_eol;
            end
        end
    end

    // Channel expansion by bit replication, then the luma weights. The
    // weights sum to 256, so the maximum sum (65280) fits in 16 bits.
    always_comb begin
        r8       = {stg_pix[15:11], stg_pix[15:13]};
        g8       = {stg_pix[10:5],  stg_pix[10:9]};
        b8       = {stg_pix[4:0],   stg_pix[4:2]};
        gray_sum = (16'd77  * {8'd0, r8})
                 + (16'd150 * {8'd0, g8})
                 + (16'd29  * {8'd0, b8});
    end

    // FIFO control. A pop in the same cycle frees a slot, so a write to a
    // full FIFO still succeeds when the consumer takes the head.
    always_comb begin
        full  = (count == FULL_CNT);
        pop   = pix_valid & pix_ready;
        wr_ok = stg_valid & (~full | pop);
        drop  = stg_valid & full & ~pop;
    end

    // FIFO storage; no reset needed since reads are gated by pix_valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {gray_sum[15:8], stg_sof, stg_eol};
        end
    end

    // FIFO pointers and occupancy. Contents persist across frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as clear_ovf keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Head outputs are forced to zero whenever the FIFO is empty.
    assign head      = mem[rd_ptr];
    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? head[9:2] : 8'd0;
    assign pix_sof   = pix_valid ? head[1]   : 1'b0;
    assign pix_eol   = pix_valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_cam_pixel_decimator.sv
// -----------------------------------------------------------------------------
// tb_cam_pixel_decimator
//
// Self-checking bench for cam_pixel_decimator on a reduced 32x16 image
// (DEC=4, FIFO_DEPTH=4). Lines and frames are driven slightly oversized so
// that the discard window is exercised. A frame-level model predicts every
// pixel the DUT must emit, and a compare process checks the FIFO head on
// every cycle that it is valid.
// -----------------------------------------------------------------------------
module tb_cam_pixel_decimator;

    localparam int IW     = 32;
    localparam int IH     = 16;
    localparam int D      = 4;
    localparam int FD     = 4;
    localparam int NLINES = 18;
    localparam int NBYTES = 68;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cam_vsync;
    logic       cam_href;
    logic       cam_byte_valid;
    logic [7:0] cam_byte;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_sof;
    logic       pix_eol;
    logic       frame_done;
    logic       overflow;
    logic       clear_ovf;

    always #5 clk = ~clk;

    cam_pixel_decimator #(
        .IMG_W(IW), .IMG_H(IH), .DEC(D), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_byte_valid(cam_byte_valid), .cam_byte(cam_byte),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } pix_t;

    pix_t exp_q[$];
    pix_t got[$];
    pix_t head_exp;

    int   checks     = 0;
    int   errors     = 0;
    int   fd_count   = 0;
    int   exp_fd     = 0;
    bit   capturing  = 1'b0;
    bit   armed      = 1'b0;
    bit   stall_mode = 1'b0;

    logic [7:0] line_buf [0:127];

    // Grayscale reference from the RGB565 word using plain integer math
    function automatic int gray_model(input logic [7:0] hi, input logic [7:0] lo);
        int p, r5, g6, b5, r8, g8, b8;
        p  = int'({hi, lo});
        r5 = (p >> 11) & 31;
        g6 = (p >> 5) & 63;
        b5 = p & 31;
        r8 = (r5 << 3) | (r5 >> 2);
        g8 = (g6 << 2) | (g6 >> 4);
        b8 = (b5 << 3) | (b5 >> 2);
        return (77 * r8 + 150 * g8 + 29 * b8) >> 8;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: byte i of line r completes pixel i/2 when i is odd
    task automatic model_byte(input int r, input int i);
        int   k;
        pix_t e;
        if (capturing && (i % 2 == 1)) begin
            k = i / 2;
            if (r < IH && k < IW && (k % D) == 0 && (r % D) == 0) begin
                e.data = 8'(gray_model(line_buf[i-1], line_buf[i]));
                e.sof  = (r == 0 && k == 0);
                e.eol  = (k == IW - D);
                if (!(stall_mode && exp_q.size() >= FD)) begin
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            line_buf[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic send_bytes(input int r, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            cam_byte       = line_buf[i];
            cam_byte_valid = 1'b1;
            model_byte(r, i);
            tick();
        end
        cam_byte_valid = 1'b0;
    endtask

    task automatic line_end();
        cam_byte_valid = 1'b0;
        cam_href       = 1'b0;
        repeat (3) tick();
    endtask

    // One complete random line of n bytes for row r
    task automatic applyStimulus(input int r, input int n);
        fill_random(n);
        cam_href = 1'b1;
        send_bytes(r, 0, n);
        line_end();
    endtask

    task automatic run_lines(input int first, input int last, input int n);
        for (int r = first; r < last; r++) begin
            applyStimulus(r, n);
        end
    endtask

    // VSYNC pulse: the rise ends any capture, the fall starts one if armed
    task automatic vsync_pulse();
        if (capturing) begin
            exp_fd++;
            armed     = enable;
            capturing = 1'b0;
        end else if (enable) begin
            armed = 1'b1;
        end
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        tick();
        if (armed) begin
            capturing = 1'b1;
            armed     = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(negedge clk);
        end
        checkOutput("drain_empty", exp_q.size(), 0);
        repeat (4) tick();
    endtask

    task automatic check_frame(input int exp_n, input int exp_eol);
        int n_eol = 0;
        int n_sof = 0;
        foreach (got[i]) begin
            if (got[i].eol) n_eol++;
            if (got[i].sof) n_sof++;
        end
        checkOutput("frame_pixels", got.size(), exp_n);
        checkOutput("frame_eol_count", n_eol, exp_eol);
        checkOutput("frame_sof_count", n_sof, 1);
        if (got.size() > 0) begin
            checkOutput("first_sof", got[0].sof, 1);
        end
        got.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_pix_valid"}, pix_valid, 0);
        checkOutput({tag, "_pix_data"}, pix_data, 0);
        checkOutput({tag, "_pix_sof"}, pix_sof, 0);
        checkOutput({tag, "_pix_eol"}, pix_eol, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
    endtask

    // Compare process: FIFO head against the model on every valid cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) fd_count++;
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pixel: got data=%0d sof=%0d eol=%0d, expected none (t=%0t)",
                             pix_data, pix_sof, pix_eol, $time);
                    if (pix_ready) got.push_back({pix_data, pix_sof, pix_eol});
                end else begin
                    head_exp = exp_q[0];
                    checkOutput("pixel_head", {22'd0, pix_data, pix_sof, pix_eol},
                                {22'd0, head_exp.data, head_exp.sof, head_exp.eol});
                    if (pix_ready) begin
                        got.push_back({pix_data, pix_sof, pix_eol});
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        cam_vsync      = 1'b0;
        cam_href       = 1'b0;
        cam_byte_valid = 1'b0;
        cam_byte       = 8'd0;
        pix_ready      = 1'b1;
        clear_ovf      = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Frame 1: known colours, pipeline latency, full-frame statistics
        enable = 1'b1;
        vsync_pulse();
        fill_random(NBYTES);
        line_buf[0]  = 8'hF8; line_buf[1]  = 8'h00;
        line_buf[8]  = 8'hFF; line_buf[9]  = 8'hFF;
        line_buf[16] = 8'h07; line_buf[17] = 8'hE0;
        cam_href = 1'b1;
        send_bytes(0, 0, 2);
        @(negedge clk);
        checkOutput("latency_n1_empty", pix_valid, 0);
        @(negedge clk);
        checkOutput("latency_n2_valid", pix_valid, 1);
        tick();
        send_bytes(0, 2, NBYTES);
        line_end();
        run_lines(1, NLINES, NBYTES);
        vsync_pulse();
        drain();
        if (got.size() >= 3) begin
            checkOutput("gray_red", got[0].data, 76);
            checkOutput("gray_white", got[1].data, 255);
            checkOutput("gray_green", got[2].data, 149);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL literal_pixels: got %0d pixels, expected at least 3", got.size());
        end
        check_frame(32, 4);
        checkOutput("frame_done_f1", fd_count, 1);

        // Frame 2: odd byte count on every line
        run_lines(0, NLINES, NBYTES + 1);
        vsync_pulse();
        drain();
        check_frame(32, 4);
        checkOutput("frame_done_f2", fd_count, 2);

        // Frame 3: consumer stalled for a whole line
        pix_ready  = 1'b0;
        stall_mode = 1'b1;
        applyStimulus(0, NBYTES);
        repeat (4) tick();
        @(negedge clk);
        checkOutput("overflow_set", overflow, 1);
        checkOutput("stalled_valid", pix_valid, 1);
        tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        @(negedge clk);
        checkOutput("overflow_cleared", overflow, 0);
        tick();
        pix_ready  = 1'b1;
        stall_mode = 1'b0;
        drain();
        checkOutput("retained_pixels", got.size(), FD);
        got.delete();
        vsync_pulse();
        checkOutput("frame_done_f3", fd_count, 3);

        // Frame 4: enable dropped mid-frame, frame still completes
        run_lines(0, 9, NBYTES);
        enable = 1'b0;
        run_lines(9, NLINES, NBYTES);
        vsync_pulse();
        drain();
        check_frame(32, 4);
        checkOutput("frame_done_f4", fd_count, 4);

        // Frame 5: idle, nothing captured
        run_lines(0, NLINES, NBYTES);
        vsync_pulse();
        drain();
        checkOutput("idle_no_pixels", got.size(), 0);
        checkOutput("idle_no_frame_done", fd_count, 4);

        // Frame 6: reset mid-line, rest of frame ignored; frame 7 captured
        enable = 1'b1;
        vsync_pulse();
        run_lines(0, 5, NBYTES);
        fill_random(NBYTES);
        cam_href = 1'b1;
        send_bytes(5, 0, 30);
        rst       = 1'b1;
        exp_q.delete();
        capturing = 1'b0;
        armed     = 1'b0;
        tick();
        @(negedge clk);
        check_reset_outputs("midline_reset");
        tick();
        rst = 1'b0;
        got.delete();
        send_bytes(5, 30, NBYTES);
        line_end();
        run_lines(6, NLINES, NBYTES);
        vsync_pulse();
        drain();
        checkOutput("after_reset_ignored", got.size(), 0);
        checkOutput("after_reset_no_frame_done", fd_count, 4);
        run_lines(0, NLINES, NBYTES);
        vsync_pulse();
        drain();
        check_frame(32, 4);
        checkOutput("frame_done_f7", fd_count, 5);
        checkOutput("frame_done_model", fd_count, exp_fd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
